spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave endpoint that sits directly downstream of the SpiMaster serial pins: consumes SCLK/MOSI/CS, drives MISO.
- Presents received bytes on a parallel valid pulse and accepts transmit bytes through a one-deep ready/valid holding register.
- Fully synchronous to the system clock: SPI inputs are synchronised and edge-detected, not used as clocks.
- Supports all four CPOL/CPHA modes, selected at run time. Serves as the on-chip peer and loopback target for master verification.

Parameters:
DATA_WIDTH, 8, bits per SPI word; MSB first.
SYNC_STAGES, 2, synchroniser flops on iSpiClk, iSpiCs and iSpiMosi (minimum 2).
TX_IDLE, 8'hFF, word shifted out when the holding register is empty at load time.

Ports:
iClk  in  1  system clock.
iRstN  in  1  reset; synchronous, active-low.
iCpol  in  1  SCLK idle level; static while iSpiCs is low.
iCpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while iSpiCs is low.
iSpiCs  in  1  chip select, active low, asynchronous.
iSpiClk  in  1  SPI clock, asynchronous.
iSpiMosi  in  1  master-out data, asynchronous.
oSpiMiso  out  1  slave-out data (registered).
oSpiMisoOe  out  1  MISO output enable; high while selected.
iTxData  in  DATA_WIDTH  next word to transmit.
iTxValid  in  1  iTxData valid.
oTxReady  out  1  holding register empty; a transfer occurs when iTxValid && oTxReady.
oRxData  out  DATA_WIDTH  last complete received word; held until the next one.
oRxValid  out  1  one-cycle pulse when oRxData updates.
oBusy  out  1  synchronised chip select active.

Behaviour:
- Reset (iRstN low at a rising iClk edge):
  - Synchronisers cleared to the idle levels (Cs=1, Clk=iCpol, Mosi=0).
  - Bit counter 0; shift registers 0; holding register empty.
  - Outputs: oSpiMiso=0, oSpiMisoOe=0, oRxData=0, oRxValid=0, oBusy=0.
  - oTxReady = !holdValid, so it reads 1 during and after reset.
  - A reset mid-transfer aborts the transfer with no oRxValid.
- Edge detection:
  - sclkPrev holds the last synchronised SCLK.
  - Leading edge = rise when iCpol=0, fall when iCpol=1; trailing edge is the opposite.
  - Sample edge = leading if iCpha=0, trailing if iCpha=1. Shift edge = the other edge.
  - Edges are ignored while the synchronised CS is high.
- Timing requirement: SCLK high and low times must each be ≥ SYNC_STAGES+1 iClk periods. The SpiMaster with CLK_DIV_COUNT=10 meets this.
- FSM:
  - IDLE: CS high; oSpiMisoOe=0; bit count=0.
  - IDLE -> ACTIVE on synchronised CS falling. That cycle: oBusy=1, oSpiMisoOe=1. If iCpha=0, the tx shift register loads (holding word or TX_IDLE) and oSpiMiso = bit MSB.
  - ACTIVE -> IDLE on synchronised CS rising, in any state. The partial rx word and tx shift contents are discarded, bit count returns to 0, and no oRxValid is produced. The holding register is preserved.
- Sample edge (ACTIVE):
  - rxShift <= {rxShift[W-2:0], mosiSync}; count++.
  - On count reaching DATA_WIDTH: oRxData <= completed word, oRxValid=1 for the next cycle only, count <= 0.
  - Latency from raw SCLK edge to oRxValid is at most SYNC_STAGES+2 iClk.
- Shift edge (ACTIVE):
  - If count==0, load the tx shift register (holding word if holdValid, else TX_IDLE) and clear holdValid.
  - Otherwise shift left by one.
  - oSpiMiso follows shift-register MSB on the next iClk.
  - For CPHA=0 the first word is loaded at CS fall instead, since its first shift edge sees count=1.
- Holding register:
  - Captures iTxData when iTxValid && oTxReady.
  - If a load and a capture coincide while empty, the load takes TX_IDLE and the capture fills the holding register.
  - While full, oTxReady=0 and iTxData is ignored.
- No receive backpressure: an unconsumed oRxData is overwritten by the next word.

Test Plan:
- Mode 3 (CPOL=1, CPHA=1), slave holding preloaded 8'h3C, master sends 8'h5A -> one oRxValid pulse with oRxData=8'h5A; master oDout=8'h3C; oTxReady returns to 1 at the first shift edge.
- Mode 0, 1 and 2, same bytes -> identical results in each mode; MISO stable at every master sample edge.
- Two back-to-back words with CS held low, 8'h11 then 8'h22 queued (second written after oTxReady rises) -> master receives 8'h11, 8'h22; slave receives both master words with two oRxValid pulses.
- Empty holding register, master sends 8'hA5 -> master receives 8'hFF (TX_IDLE); oRxData=8'hA5.
- CS raised after 4 SCLK cycles, then a full transfer of 8'hC3 -> no pulse for the aborted word; one pulse with oRxData=8'hC3 and correct MISO for the second.
- iRstN low for one cycle mid-byte -> all outputs at reset values the next cycle; no oRxValid; the following CS-framed word is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave endpoint, fully synchronous to iClk: SPI pins are synchronised and edge-detected.
// All four CPOL/CPHA modes; MSB-first words; one-deep transmit holding register.
module spi_slave #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = {DATA_WIDTH{1'b1}}
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iCpol,
    input  logic                  iCpha,
    input  logic                  iSpiCs,
    input  logic                  iSpiClk,
    input  logic                  iSpiMosi,
    output logic                  oSpiMiso,
    output logic                  oSpiMisoOe,
    input  logic [DATA_WIDTH-1:0] iTxData,
    input  logic                  iTxValid,
    output logic                  oTxReady,
    output logic [DATA_WIDTH-1:0] oRxData,
    output logic                  oRxValid,
    output logic                  oBusy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic                  r_miso;
    logic                  r_oe;
    logic                  r_busy;

    logic                  w_cs;
    logic                  w_sclk;
    logic                  w_mosi;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample_edge;
    logic                  w_shift_edge;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_load;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_load_word;

    // Synchronisers reset to the bus idle levels so no phantom edge appears after reset.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_cs_sync   <= '1;
            r_clk_sync  <= {SYNC_STAGES{iCpol}};
            r_mosi_sync <= '0;
            r_sclk_prev <= iCpol;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], iSpiCs};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], iSpiClk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], iSpiMosi};
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_clk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_rise        = w_sclk & ~r_sclk_prev;
    assign w_fall        = ~w_sclk & r_sclk_prev;
    assign w_lead        = iCpol ? w_fall : w_rise;
    assign w_trail       = iCpol ? w_rise : w_fall;
    assign w_sample_edge = iCpha ? w_trail : w_lead;
    assign w_shift_edge  = iCpha ? w_lead : w_trail;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cs) begin
                    w_state_next = S_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_sample = w_sample_edge;
                    w_shift  = w_shift_edge;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // CPHA=0 presents its first MSB before any clock edge, so it loads at selection.
    assign w_load      = (w_start & ~iCpha) | (w_shift & (r_bit_cnt == '0));
    assign w_load_word = r_hold_valid ? r_hold : TX_IDLE;
    assign w_capture   = iTxValid & ~r_hold_valid;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_busy <= 1'b1;
                r_oe   <= 1'b1;
            end
            if (w_abort) begin
                r_busy     <= 1'b0;
                r_oe       <= 1'b0;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= '0;
                r_miso     <= 1'b0;
            end
            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    r_rx_data  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
            if (w_load) begin
                r_tx_shift <= w_load_word;
                r_miso     <= w_load_word[DATA_WIDTH-1];
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[DATA_WIDTH-2];
            end
            // A load from an empty register takes TX_IDLE, leaving room for a same-cycle capture.
            if (w_load && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end else if (w_capture) begin
                r_hold       <= iTxData;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign oSpiMiso   = r_miso;
    assign oSpiMisoOe = r_oe;
    assign oTxReady   = ~r_hold_valid;
    assign oRxData    = r_rx_data;
    assign oRxValid   = r_rx_valid;
    assign oBusy      = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master plus a transaction-level
// model of the holding register (pending-word queue) and of the received words.
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 6;
    localparam logic [W-1:0] IDLE_WORD = 8'hFF;

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iCpol = 1'b0;
    logic         iCpha = 1'b0;
    logic         iSpiCs = 1'b1;
    logic         iSpiClk = 1'b0;
    logic         iSpiMosi = 1'b0;
    logic         oSpiMiso;
    logic         oSpiMisoOe;
    logic [W-1:0] iTxData = '0;
    logic         iTxValid = 1'b0;
    logic         oTxReady;
    logic [W-1:0] oRxData;
    logic         oRxValid;
    logic         oBusy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];     // words the slave should transmit next, oldest first
    logic [W-1:0] rx_obs_q[$];  // words seen on oRxValid pulses

    spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2), .TX_IDLE(IDLE_WORD)) dut (
        .iClk(iClk), .iRstN(iRstN), .iCpol(iCpol), .iCpha(iCpha),
        .iSpiCs(iSpiCs), .iSpiClk(iSpiClk), .iSpiMosi(iSpiMosi),
        .oSpiMiso(oSpiMiso), .oSpiMisoOe(oSpiMisoOe),
        .iTxData(iTxData), .iTxValid(iTxValid), .oTxReady(oTxReady),
        .oRxData(oRxData), .oRxValid(oRxValid), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        #1;
        if (oRxValid) rx_obs_q.push_back(oRxData);
    end

    task automatic clks(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic set_mode(input int m);
        iCpol   = m[1];
        iCpha   = m[0];
        iSpiClk = m[1];
        clks(8);
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        int n = 0;
        while (!oTxReady && n < 500) begin
            clks(1);
            n++;
        end
        checks++;
        if (oTxReady !== 1'b1) begin
            failures++;
            $display("FAIL tx_write_ready: got %b want 1 within 500 cycles", oTxReady);
        end else begin
            iTxData  = d;
            iTxValid = 1'b1;
            clks(1);
            iTxValid = 1'b0;
            exp_q.push_back(d);
        end
    endtask

    function automatic logic [W-1:0] next_slave_word();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return IDLE_WORD;
    endfunction

    // Master side: clocks nbits MSB-first, CS already low, SCLK idle on entry and exit.
    task automatic spi_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            if (!iCpha) begin
                iSpiMosi = mo[W-1-k];
                clks(HALF);
                mi[W-1-k] = oSpiMiso;
                iSpiClk = ~iCpol;
                clks(HALF);
                iSpiClk = iCpol;
            end else begin
                iSpiClk  = ~iCpol;
                iSpiMosi = mo[W-1-k];
                clks(HALF);
                mi[W-1-k] = oSpiMiso;
                iSpiClk = iCpol;
                clks(HALF);
            end
        end
    endtask

    task automatic xfer(input logic [W-1:0] mo, input string tag);
        logic [W-1:0] mi;
        logic [W-1:0] exp_mi;
        rx_obs_q.delete();
        exp_mi = next_slave_word();
        iSpiCs = 1'b0;
        clks(HALF);
        checks++;
        if (oBusy !== 1'b1 || oSpiMisoOe !== 1'b1) begin
            failures++;
            $display("FAIL %s_select: busy=%b oe=%b want 1/1", tag, oBusy, oSpiMisoOe);
        end
        spi_bits(mo, W, mi);
        clks(HALF);
        iSpiCs = 1'b1;
        clks(HALF);
        checks++;
        if (mi !== exp_mi) begin
            failures++;
            $display("FAIL %s_miso: master got %h want %h", tag, mi, exp_mi);
        end
        checks++;
        if (rx_obs_q.size() != 1 || rx_obs_q[0] !== mo || oRxData !== mo) begin
            failures++;
            $display("FAIL %s_rx: pulses=%0d data=%h want 1 pulse of %h", tag, rx_obs_q.size(), oRxData, mo);
        end
        checks++;
        if (oBusy !== 1'b0 || oSpiMisoOe !== 1'b0) begin
            failures++;
            $display("FAIL %s_deselect: busy=%b oe=%b want 0/0", tag, oBusy, oSpiMisoOe);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (oSpiMiso !== 1'b0 || oSpiMisoOe !== 1'b0 || oRxValid !== 1'b0 || oBusy !== 1'b0) begin
            failures++;
            $display("FAIL %s_ctl: miso=%b oe=%b rxv=%b busy=%b want all 0", tag, oSpiMiso, oSpiMisoOe, oRxValid, oBusy);
        end
        checks++;
        if (oRxData !== '0) begin
            failures++;
            $display("FAIL %s_rxdata: got %h want 00", tag, oRxData);
        end
        checks++;
        if (oTxReady !== 1'b1) begin
            failures++;
            $display("FAIL %s_txready: got %b want 1", tag, oTxReady);
        end
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        clks(3);
        check_reset_outputs("reset");
        iRstN = 1'b1;
        clks(4);
    endtask

    task automatic test_mode3_basic();
        set_mode(3);
        tx_write(8'h3C);
        checks++;
        if (oTxReady !== 1'b0) begin
            failures++;
            $display("FAIL mode3_full: txready=%b want 0", oTxReady);
        end
        xfer(8'h5A, "mode3");
        checks++;
        if (oTxReady !== 1'b1) begin
            failures++;
            $display("FAIL mode3_ready_back: txready=%b want 1", oTxReady);
        end
    endtask

    task automatic test_modes_012();
        for (int m = 0; m < 3; m++) begin
            set_mode(m);
            tx_write(8'h3C);
            xfer(8'h5A, $sformatf("mode%0d", m));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] mi0, mi1, e0, e1;
        set_mode(int'($urandom_range(0, 3)));
        rx_obs_q.delete();
        tx_write(8'h11);
        iSpiCs = 1'b0;
        clks(HALF);
        fork
            begin
                e0 = next_slave_word();
                spi_bits(8'hC7, W, mi0);
                e1 = next_slave_word();
                spi_bits(8'h38, W, mi1);
            end
            tx_write(8'h22);
        join
        clks(HALF);
        iSpiCs = 1'b1;
        clks(HALF);
        checks++;
        if (mi0 !== e0 || mi1 !== e1 || e0 !== 8'h11 || e1 !== 8'h22) begin
            failures++;
            $display("FAIL b2b_miso: master got %h %h want 11 22", mi0, mi1);
        end
        checks++;
        if (rx_obs_q.size() != 2 || rx_obs_q[0] !== 8'hC7 || rx_obs_q[1] !== 8'h38) begin
            failures++;
            $display("FAIL b2b_rx: pulses=%0d last=%h want 2 pulses c7 38", rx_obs_q.size(), oRxData);
        end
    endtask

    task automatic test_empty_holding();
        set_mode(int'($urandom_range(0, 3)));
        xfer(8'hA5, "empty");
    endtask

    task automatic test_abort();
        logic [W-1:0] mi;
        set_mode(int'($urandom_range(0, 3)));
        rx_obs_q.delete();
        iSpiCs = 1'b0;
        clks(HALF);
        spi_bits(8'hF0, 4, mi);
        iSpiCs = 1'b1;
        clks(12);
        checks++;
        if (rx_obs_q.size() != 0) begin
            failures++;
            $display("FAIL abort_nopulse: pulses=%0d want 0", rx_obs_q.size());
        end
        tx_write(8'h96);
        xfer(8'hC3, "after_abort");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] mi;
        set_mode(0);
        tx_write(8'h77);
        rx_obs_q.delete();
        iSpiCs = 1'b0;
        clks(HALF);
        spi_bits(8'hB4, 4, mi);
        iRstN = 1'b0;
        clks(1);
        iRstN = 1'b1;
        exp_q.delete();
        check_reset_outputs("midreset");
        clks(4);
        iSpiCs = 1'b1;
        clks(12);
        checks++;
        if (rx_obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_nopulse: pulses=%0d want 0", rx_obs_q.size());
        end
        xfer(8'h3E, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            set_mode(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tx_write(W'($urandom));
            xfer(W'($urandom), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_mode3_basic();
        test_modes_012();
        test_back_to_back();
        test_empty_holding();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
